// File: rtl/mmio_uart_transmitter_if.sv
// rtl/mmio_uart_transmitter_if.sv - MMIO command/status word pair between CPU and UART transmitter
interface mmio_uart_transmitter_if;
    logic [31:0] txCommand;
    logic [31:0] txStatus;

    modport master (output txCommand, input txStatus);
    modport slave  (input txCommand, output txStatus);
endinterface

// File: rtl/mmio_uart_transmitter.sv
// rtl/mmio_uart_transmitter.sv - toggle-handshake MMIO UART transmitter with byte FIFO, 8N1 serialiser
// Optional even parity bit compiled in with MMIO_UART_PARITY_EN.
module mmio_uart_transmitter #(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    mmio_uart_transmitter_if.slave  bus,
    output logic                    txd
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0]              BAUD_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       r_ack;
    logic [7:0]                 r_shift;
    logic [7:0]                 w_shift_nxt;
    logic [2:0]                 r_bit_idx;
    logic [2:0]                 w_bit_idx_nxt;
    logic [CW-1:0]              r_baud;
    logic [CW-1:0]              w_baud_nxt;
    logic                       r_txd;
    logic                       w_txd_nxt;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_busy;
    logic                       w_baud_done;
    logic                       w_unused_cmd;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == COUNT_FULL);
    assign w_busy       = (r_state != S_IDLE);
    assign w_baud_done  = (r_baud == BAUD_LAST);
    // A full FIFO blocks the push even when a pop frees a slot on the same edge.
    assign w_push       = (bus.txCommand[8] != r_ack) && !w_full;
    assign w_unused_cmd = ^bus.txCommand[31:9];

    assign bus.txStatus = {16'b0, 4'(r_count), w_busy, w_empty, w_full, r_ack, 8'b0};
    assign txd          = r_txd;

`ifdef MMIO_UART_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;
    assign w_parity_nxt = w_pop ? ^r_mem[r_rd_ptr] : r_parity;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_parity <= 1'b0;
        else       r_parity <= w_parity_nxt;
    end
`endif

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.txCommand[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_ack    <= ~r_ack;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_baud    <= w_baud_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_baud_nxt    = w_baud_done ? '0 : r_baud + 1'b1;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: w_txd_nxt = w_parity_nxt;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end
endmodule
